way_victim_sel: RTL and testbench
=================================

Name: way_victim_sel

Overview:
- Replacement-state tracker for the 8-way set-associative cache.
- Keeps per-set valid bits and true-LRU age counters. On lookup, produces the 8-bit candidate vector that feeds the downstream priority encoder (lowest set bit wins).
- Sits between the tag/hit logic, which drives access updates, and the way-index encoder, which consumes victim_vec.

Parameters:
- NUM_SETS, 16, number of cache sets (power of two, at least 2).
- SET_W, 4, set index width; equals log2(NUM_SETS).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- upd_valid  input  1  access update strobe.
- upd_set  input  SET_W  set being updated.
- upd_way  input  3  way being touched.
- upd_op  input  2  update operation: 00 = hit (touch), 01 = fill (touch and set valid), 10 = invalidate (clear valid, no age change), 11 = reserved (no-op).
- lkp_req  input  1  victim lookup request.
- lkp_set  input  SET_W  set to look up.
- victim_vec  output  8  candidate way mask, registered.
- victim_ok  output  1  victim_vec valid; one-cycle pulse.
- flush  input  1  invalidate all sets; sampled only in IDLE.
- busy  output  1  high while flushing.

Behaviour:
- Reset (reset=0, asynchronous):
  - All valid bits = 0.
  - age[s][w] = w for every set s.
  - victim_vec = 8'h00, victim_ok = 0, busy = 0, FSM = IDLE.
- Age invariant: within each set, the 8 three-bit ages are always a permutation of 0..7. Age 0 is MRU, age 7 is LRU.
- Touch of way w with old age a (hit or fill):
  - age[w] becomes 0.
  - Every way with age < a increments by 1.
  - Ways with age > a are unchanged.
  - No overflow is possible.
- Lookup latency is 1 cycle: lkp_req in cycle N gives victim_vec and victim_ok=1 in cycle N+1. victim_ok is 0 in any cycle without a preceding request.
- victim_vec rule:
  - If any way in lkp_set is invalid, victim_vec = ~valid[lkp_set].
  - Otherwise victim_vec = one-hot of the way with age 7.
  - victim_vec is never all-zero when victim_ok=1.
- Simultaneous lookup and update to the same set in the same cycle: the lookup sees pre-update state (read-before-write).
- Only one update per cycle. Invalidating an already-invalid way is a no-op. Filling an already-valid way behaves as a hit plus valid=1.
- FSM:
  - IDLE: flush=1 moves to FLUSH with sweep counter = 0 and busy = 1.
  - FLUSH: clears valid[counter] each cycle and increments the counter. After clearing set NUM_SETS-1, returns to IDLE with busy=0. Total is NUM_SETS cycles.
  - Ages are untouched by flush.
  - In FLUSH, upd_valid and lkp_req are ignored: no state change, victim_ok stays 0. flush is ignored while already in FLUSH.
- Reset asserted mid-flush: immediate return to the reset state as defined above.
- victim_vec holds its last value when victim_ok=0.

Optional Feature:
- Macro: WAY_VICTIM_STATS_EN.
- When defined:
  - Adds outputs hit_cnt[15:0] and fill_cnt[15:0].
  - Each counter increments on an accepted hit or fill update respectively and saturates at 16'hFFFF.
  - Both reset to 0. Neither is cleared by flush.
- When undefined: no counters and no extra ports. Behaviour is otherwise identical.

Decomposition:
- Shared package cache_pkg holds:
  - WAYS = 8, WAY_W = 3, AGE_W = 3.
  - upd_op encodings OP_HIT, OP_FILL, OP_INV.
  - The age-vector typedef (8 x AGE_W).
- One sub-module, lru_age_update: purely combinational. Takes the current 8 ages of a set plus the touched way, and returns the next 8 ages. It is reused by the stats-free and stats builds alike.

Test Plan:
- After reset, lkp_req on set 3 -> the next cycle gives victim_vec=8'hFF and victim_ok=1. Every age in set 3 equals its way index.
- Fill ways 0..7 of set 2 in order, then look up set 2 -> victim_vec=8'h01, since way 0 is the oldest at age 7.
- Continuing from that state, hit way 0, then look up -> victim_vec=8'h02. Check set 2 ages: way 0=0, way 7=1, way 1=7.
- Invalidate way 5 of full set 2 -> lookup gives victim_vec=8'h20 regardless of ages.
- Same-cycle lookup of set 2 and hit of the current LRU way in set 2 -> returned victim_vec is that way's one-hot (pre-update). A lookup one cycle later returns the new LRU.
- flush with NUM_SETS=16 -> busy is high for exactly 16 cycles and updates/lookups issued during that window are ignored. Afterwards every set reads 8'hFF.
- A separate run asserts reset in flush cycle 5 -> busy=0 immediately.

Source files
------------

// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the 8-way set-associative cache replacement logic.
//   WAYS / WAY_W / AGE_W : associativity, way index width, age counter width
//   upd_op_t             : access update operation encodings
//   age_vec_t            : the eight per-way ages of one set (way 0 in LSBs)
//   fsm_t                : replacement tracker control states
//   age_init()           : reset age vector, age[w] = w
// -----------------------------------------------------------------------------
package cache_pkg;

  localparam int WAYS  = 8;
  localparam int WAY_W = 3;
  localparam int AGE_W = 3;

  typedef enum logic [1:0] {
    OP_HIT  = 2'b00,
    OP_FILL = 2'b01,
    OP_INV  = 2'b10,
    OP_RSV  = 2'b11
  } upd_op_t;

  typedef logic [WAYS-1:0][AGE_W-1:0] age_vec_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } fsm_t;

  function automatic age_vec_t age_init();
    age_vec_t a;
    for (int w = 0; w < WAYS; w++) begin
      a[w] = AGE_W'(w);
    end
    return a;
  endfunction

endpackage

// File: rtl/lru_age_update.sv
// -----------------------------------------------------------------------------
// lru_age_update
// Combinational true-LRU age update for one set. The touched way becomes MRU
// (age 0); every way younger than the touched way ages by one; older ways are
// unchanged. Because the ages form a permutation of 0..7, no age can pass 7.
// Ports:
//   age_cur : current ages of the set
//   way     : way being touched
//   age_nxt : ages after the touch
// -----------------------------------------------------------------------------
module lru_age_update
  import cache_pkg::*;
(
  input  age_vec_t           age_cur,
  input  logic [WAY_W-1:0]   way,
  output age_vec_t           age_nxt
);

  logic [AGE_W-1:0] old_age;

  always_comb begin
    old_age = age_cur[way];
    age_nxt = age_cur;
    for (int w = 0; w < WAYS; w++) begin
      if (way == WAY_W'(w)) begin
        age_nxt[w] = '0;
      end else if (age_cur[w] < old_age) begin
        age_nxt[w] = age_cur[w] + AGE_W'(1);
      end
    end
  end

endmodule

// File: rtl/way_victim_sel.sv
// -----------------------------------------------------------------------------
// way_victim_sel
// Replacement-state tracker for the 8-way cache: per-set valid bits and
// true-LRU ages, a one-cycle victim lookup, and a sweeping flush that clears
// the valid bits of one set per cycle (ages are kept).
// Optional build macro: WAY_VICTIM_STATS_EN adds saturating hit/fill counters.
// Ports:
//   clk, reset           : clock, asynchronous active-low reset
//   upd_valid/set/way/op : access update from tag/hit logic
//   lkp_req, lkp_set     : victim lookup request
//   victim_vec           : registered candidate way mask (holds when not valid)
//   victim_ok            : one-cycle pulse, victim_vec valid
//   flush                : start flush (sampled only when idle)
//   busy                 : high while flushing
//   hit_cnt, fill_cnt    : accepted hit / fill counts (WAY_VICTIM_STATS_EN)
// -----------------------------------------------------------------------------
module way_victim_sel
  import cache_pkg::*;
#(
  parameter int NUM_SETS = 16,
  parameter int SET_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              upd_valid,
  input  logic [SET_W-1:0]  upd_set,
  input  logic [WAY_W-1:0]  upd_way,
  input  logic [1:0]        upd_op,
  input  logic              lkp_req,
  input  logic [SET_W-1:0]  lkp_set,
  output logic [WAYS-1:0]   victim_vec,
  output logic              victim_ok,
  input  logic              flush,
  output logic              busy
`ifdef WAY_VICTIM_STATS_EN
  ,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       fill_cnt
`endif
);

  fsm_t              state_q, state_d;
  logic [SET_W-1:0]  cnt_q, cnt_d;

  logic [WAYS-1:0]   valid_q [NUM_SETS];
  age_vec_t          age_q   [NUM_SETS];

  logic              idle;
  logic              upd_acc;
  logic              lkp_acc;
  upd_op_t           op;

  age_vec_t          upd_age_cur;
  age_vec_t          upd_age_nxt;

  logic [WAYS-1:0]   lk_valid;
  age_vec_t          lk_age;
  logic [WAYS-1:0]   lk_lru;
  logic [WAYS-1:0]   lk_vec;

  logic [WAYS-1:0]   vec_p1;
  logic              vld_p1;

  assign idle    = (state_q == ST_IDLE);
  assign upd_acc = upd_valid & idle;
  assign lkp_acc = lkp_req & idle;
  assign op      = upd_op_t'(upd_op);
  assign busy    = (state_q == ST_FLUSH);

  assign upd_age_cur = age_q[upd_set];

  lru_age_update u_lru (
    .age_cur (upd_age_cur),
    .way     (upd_way),
    .age_nxt (upd_age_nxt)
  );

  // Lookup reads the registered state, so a same-cycle update to the same set
  // is not visible until the following lookup.
  always_comb begin
    lk_valid = valid_q[lkp_set];
    lk_age   = age_q[lkp_set];
    lk_lru   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (lk_age[w] == AGE_W'(WAYS - 1)) begin
        lk_lru[w] = 1'b1;
      end
    end
    lk_vec = (&lk_valid) ? lk_lru : ~lk_valid;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (flush) begin
          state_d = ST_FLUSH;
          cnt_d   = '0;
        end
      end
      ST_FLUSH: begin
        cnt_d = cnt_q + SET_W'(1);
        if (cnt_q == SET_W'(NUM_SETS - 1)) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        age_q[s]   <= age_init();
      end
    end else if (busy) begin
      valid_q[cnt_q] <= '0;
    end else if (upd_acc) begin
      case (op)
        OP_HIT: begin
          age_q[upd_set] <= upd_age_nxt;
        end
        OP_FILL: begin
          age_q[upd_set]            <= upd_age_nxt;
          valid_q[upd_set][upd_way] <= 1'b1;
        end
        OP_INV: begin
          valid_q[upd_set][upd_way] <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  // ---- p1: registered lookup result ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1 <= 1'b0;
      vec_p1 <= '0;
    end else begin
      vld_p1 <= lkp_acc;
      if (lkp_acc) begin
        vec_p1 <= lk_vec;
      end
    end
  end

  assign victim_vec = vec_p1;
  assign victim_ok  = vld_p1;

`ifdef WAY_VICTIM_STATS_EN
  logic [15:0] hit_cnt_q;
  logic [15:0] fill_cnt_q;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_cnt_q  <= '0;
      fill_cnt_q <= '0;
    end else begin
      if (upd_acc && (op == OP_HIT)) begin
        hit_cnt_q <= sat_inc16(hit_cnt_q);
      end
      if (upd_acc && (op == OP_FILL)) begin
        fill_cnt_q <= sat_inc16(fill_cnt_q);
      end
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign fill_cnt = fill_cnt_q;
`endif

endmodule

// File: tb/tb_way_victim_sel.sv
module tb_way_victim_sel;
  import cache_pkg::*;

  localparam int NUM_SETS = 16;
  localparam int SET_W    = 4;

  logic              clk;
  logic              reset;
  logic              upd_valid;
  logic [SET_W-1:0]  upd_set;
  logic [2:0]        upd_way;
  logic [1:0]        upd_op;
  logic              lkp_req;
  logic [SET_W-1:0]  lkp_set;
  logic [7:0]        victim_vec;
  logic              victim_ok;
  logic              flush;
  logic              busy;
`ifdef WAY_VICTIM_STATS_EN
  logic [15:0]       hit_cnt;
  logic [15:0]       fill_cnt;
`endif

  int vectors    = 0;
  int miscompares = 0;
  int cyc;

  way_victim_sel #(.NUM_SETS(NUM_SETS), .SET_W(SET_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .upd_valid  (upd_valid),
    .upd_set    (upd_set),
    .upd_way    (upd_way),
    .upd_op     (upd_op),
    .lkp_req    (lkp_req),
    .lkp_set    (lkp_set),
    .victim_vec (victim_vec),
    .victim_ok  (victim_ok),
    .flush      (flush),
    .busy       (busy)
`ifdef WAY_VICTIM_STATS_EN
    ,
    .hit_cnt    (hit_cnt),
    .fill_cnt   (fill_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] ages8(input int a0, input int a1, input int a2, input int a3,
                                        input int a4, input int a5, input int a6, input int a7);
    return {3'(a7), 3'(a6), 3'(a5), 3'(a4), 3'(a3), 3'(a2), 3'(a1), 3'(a0)};
  endfunction

  task automatic upd(input int s, input int w, input logic [1:0] o);
    upd_valid = 1'b1;
    upd_set   = SET_W'(s);
    upd_way   = 3'(w);
    upd_op    = o;
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic lookup(input string tag, input int s, input logic [7:0] exp);
    lkp_req = 1'b1;
    lkp_set = SET_W'(s);
    tick();
    lkp_req = 1'b0;
    chk({tag, "_ok"}, 32'(victim_ok), 32'd1);
    chk({tag, "_vec"}, 32'(victim_vec), 32'(exp));
  endtask

  initial begin
    reset     = 1'b0;
    upd_valid = 1'b0;
    upd_set   = '0;
    upd_way   = '0;
    upd_op    = 2'b00;
    lkp_req   = 1'b0;
    lkp_set   = '0;
    flush     = 1'b0;

    repeat (2) tick();
    chk("rst_vec", 32'(victim_vec), 32'h00);
    chk("rst_ok", 32'(victim_ok), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_age3", 32'(dut.age_q[3]), 32'(ages8(0, 1, 2, 3, 4, 5, 6, 7)));
    reset = 1'b1;
    tick();

    lookup("empty_set3", 3, 8'hFF);
    tick();
    chk("idle_ok", 32'(victim_ok), 32'd0);
    chk("hold_vec", 32'(victim_vec), 32'hFF);

    for (int w = 0; w < 8; w++) upd(2, w, 2'b01);
    lookup("full_set2", 2, 8'h01);
    chk("age_fill", 32'(dut.age_q[2]), 32'(ages8(7, 6, 5, 4, 3, 2, 1, 0)));

    upd(2, 0, 2'b00);
    lookup("hit_w0", 2, 8'h02);
    chk("age_hit", 32'(dut.age_q[2]), 32'(ages8(0, 7, 6, 5, 4, 3, 2, 1)));

    upd(2, 1, 2'b11);
    lookup("reserved", 2, 8'h02);

    upd(2, 5, 2'b10);
    lookup("inv_w5", 2, 8'h20);
    upd(2, 5, 2'b10);
    lookup("inv_again", 2, 8'h20);
    chk("age_inv", 32'(dut.age_q[2]), 32'(ages8(0, 7, 6, 5, 4, 3, 2, 1)));

    upd(2, 5, 2'b01);
    chk("age_refill", 32'(dut.age_q[2]), 32'(ages8(1, 7, 6, 5, 4, 0, 3, 2)));
    lookup("refill", 2, 8'h02);

    // Same-cycle lookup and hit of the LRU way.
    upd_valid = 1'b1; upd_set = 4'd2; upd_way = 3'd1; upd_op = 2'b00;
    lkp_req = 1'b1; lkp_set = 4'd2;
    tick();
    upd_valid = 1'b0; lkp_req = 1'b0;
    chk("rbw_ok", 32'(victim_ok), 32'd1);
    chk("rbw_vec", 32'(victim_vec), 32'h02);
    chk("age_rbw", 32'(dut.age_q[2]), 32'(ages8(2, 0, 7, 6, 5, 1, 4, 3)));
    lookup("after_rbw", 2, 8'h04);

`ifdef WAY_VICTIM_STATS_EN
    chk("hit_cnt", 32'(hit_cnt), 32'd2);
    chk("fill_cnt", 32'(fill_cnt), 32'd9);
`endif

    // Flush: traffic during the sweep must be ignored.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 40) begin
      cyc++;
      upd_valid = 1'b1; upd_set = 4'd5; upd_way = 3'd3; upd_op = 2'b01;
      lkp_req = 1'b1; lkp_set = 4'd2;
      flush = 1'b1;
      tick();
      chk("flush_ok", 32'(victim_ok), 32'd0);
    end
    upd_valid = 1'b0; lkp_req = 1'b0; flush = 1'b0;
    chk("busy_cycles", 32'(cyc), 32'd16);
    chk("flush_hold_vec", 32'(victim_vec), 32'h04);
    chk("flush_age5", 32'(dut.age_q[5]), 32'(ages8(0, 1, 2, 3, 4, 5, 6, 7)));
    chk("flush_age2", 32'(dut.age_q[2]), 32'(ages8(2, 0, 7, 6, 5, 1, 4, 3)));
    for (int s = 0; s < NUM_SETS; s++) lookup("post_flush", s, 8'hFF);

`ifdef WAY_VICTIM_STATS_EN
    chk("hit_cnt_flush", 32'(hit_cnt), 32'd2);
    chk("fill_cnt_flush", 32'(fill_cnt), 32'd9);
`endif

    // Reset during the fifth flush cycle.
    upd(2, 0, 2'b01);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (4) tick();
    chk("mid_busy_pre", 32'(busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_vec", 32'(victim_vec), 32'h00);
    chk("mid_ok", 32'(victim_ok), 32'd0);
    chk("mid_age2", 32'(dut.age_q[2]), 32'(ages8(0, 1, 2, 3, 4, 5, 6, 7)));
    tick();
    reset = 1'b1;
    tick();
    chk("mid_idle", 32'(busy), 32'd0);
    lookup("mid_set2", 2, 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
